// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: edge-detects each completed word and queues it
// with its frame-error flag. Exposes a registered pop port, fill level, sticky overflow and a level IRQ.
module uart_rx_fifo #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_new_data,
    input  logic                  rx_frame_error,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_ferr,
    output logic                  rd_valid,
    input  logic                  flush,
    input  logic                  clear_ovf,
    input  logic [DEPTH_LOG2:0]   irq_level,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam int ENT_W = DATA_W + 1;
    localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    // Storage: {frame_error, data}; no reset so it maps onto block RAM
    logic [ENT_W-1:0] mem [DEPTH];

    logic                  new_d_reg;
    logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]      level_reg, level_next;
    logic                  empty_reg, empty_next;
    logic                  full_reg, full_next;
    logic                  overflow_reg, overflow_next;
    logic                  irq_reg, irq_next;
    logic                  rd_valid_reg;
    logic [DATA_W-1:0]     rd_data_reg;
    logic                  rd_ferr_reg;

    logic push_evt;
    logic pop_req;
    logic do_push;
    logic do_pop;
    logic drop;

    // A word already high when reset releases is ignored because new_d resets to 1
    assign push_evt = rx_new_data & ~new_d_reg;
    assign pop_req  = rd_en & ~empty_reg;
    assign do_pop   = pop_req & ~flush;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then
    assign do_push  = push_evt & ~flush & (~full_reg | pop_req);
    assign drop     = push_evt & ~flush & full_reg & ~pop_req;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        level_next    = level_reg;
        overflow_next = overflow_reg;

        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   level_next = level_reg + LVL_ONE;
                2'b01:   level_next = level_reg - LVL_ONE;
                default: level_next = level_reg;
            endcase
        end

        // A dropped word in the same cycle as clear_ovf keeps the flag set
        if (clear_ovf) begin
            overflow_next = 1'b0;
        end
        if (drop) begin
            overflow_next = 1'b1;
        end

        empty_next = (level_next == '0);
        full_next  = (level_next == LVL_FULL);
        // Compared against the registered level, so irq trails level by one cycle
        irq_next   = (irq_level != '0) && (level_reg >= irq_level);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            new_d_reg    <= 1'b1;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            empty_reg    <= 1'b1;
            full_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            irq_reg      <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            new_d_reg    <= rx_new_data;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            empty_reg    <= empty_next;
            full_reg     <= full_next;
            overflow_reg <= overflow_next;
            irq_reg      <= irq_next;
            rd_valid_reg <= do_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= {rx_frame_error, rx_data};
        end
    end

    // Registered read port; read-before-write gives the oldest word on push+pop when full
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
            rd_ferr_reg <= 1'b0;
        end else if (do_pop) begin
            {rd_ferr_reg, rd_data_reg} <= mem[rd_ptr_reg];
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_ferr  = rd_ferr_reg;
    assign rd_valid = rd_valid_reg;
    assign level    = level_reg;
    assign empty    = empty_reg;
    assign full     = full_reg;
    assign overflow = overflow_reg;
    assign irq      = irq_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: ordering, edge detection, overflow, wrap,
// frame-error flag, IRQ threshold, flush and mid-stream reset.
module tb_uart_rx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rx_data;
    logic        rx_new_data;
    logic        rx_frame_error;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_ferr;
    logic        rd_valid;
    logic        flush;
    logic        clear_ovf;
    logic [4:0]  irq_level;
    logic [4:0]  level;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        irq;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_W(16), .DEPTH_LOG2(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_new_data    (rx_new_data),
        .rx_frame_error (rx_frame_error),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_ferr        (rd_ferr),
        .rd_valid       (rd_valid),
        .flush          (flush),
        .clear_ovf      (clear_ovf),
        .irq_level      (irq_level),
        .level          (level),
        .empty          (empty),
        .full           (full),
        .overflow       (overflow),
        .irq            (irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic fe);
        rx_data        = d;
        rx_frame_error = fe;
        rx_new_data    = 1'b1;
        tick();
        rx_new_data = 1'b0;
        tick();
        $display("push data=%h ferr=%0b -> level=%0d full=%0b ovf=%0b", d, fe, level, full, overflow);
    endtask

    // One pop; returns the outputs seen one cycle after rd_en, then idles a cycle
    task automatic do_pop(output logic v, output logic [15:0] d, output logic fe);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        v  = rd_valid;
        d  = rd_data;
        fe = rd_ferr;
        $display("pop  valid=%0b data=%h ferr=%0b level=%0d", v, d, fe, level);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_data = '0; rx_new_data = 1'b0; rx_frame_error = 1'b0;
        rd_en = 1'b0; flush = 1'b0; clear_ovf = 1'b0; irq_level = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total_cnt++;
        if ({level, empty, full, overflow, irq, rd_valid} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_status got lvl=%0d e=%0b f=%0b o=%0b i=%0b v=%0b exp lvl=0 e=1 f=0 o=0 i=0 v=0",
                     level, empty, full, overflow, irq, rd_valid);
        else pass_cnt++;
        total_cnt++;
        if ({rd_ferr, rd_data} !== 17'h0)
            $display("FAIL reset_rd_data got %h/%0b exp 0000/0", rd_data, rd_ferr);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic v, fe;
        logic [15:0] d;
        logic [15:0] exp_d;
        push(16'h0041, 1'b0);
        push(16'h0042, 1'b0);
        push(16'h0043, 1'b0);
        total_cnt++;
        if (level !== 5'd3 || empty !== 1'b0)
            $display("FAIL basic_level got %0d/e=%0b exp 3/e=0", level, empty);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            exp_d = 16'h0041 + 16'(i);
            do_pop(v, d, fe);
            total_cnt++;
            if ({v, fe, d} !== {1'b1, 1'b0, exp_d})
                $display("FAIL basic_pop%0d got v=%0b d=%h exp v=1 d=%h", i, v, d, exp_d);
            else pass_cnt++;
        end
        total_cnt++;
        if (empty !== 1'b1 || level !== 5'd0 || rd_valid !== 1'b0)
            $display("FAIL basic_empty got e=%0b lvl=%0d v=%0b exp e=1 lvl=0 v=0", empty, level, rd_valid);
        else pass_cnt++;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total_cnt++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0043 || level !== 5'd0)
            $display("FAIL pop_when_empty got v=%0b d=%h lvl=%0d exp v=0 d=0043 lvl=0", rd_valid, rd_data, level);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_hold();
        logic v, fe;
        logic [15:0] d;
        rx_data = 16'h0077;
        rx_frame_error = 1'b0;
        rx_new_data = 1'b1;
        repeat (50) tick();
        rx_new_data = 1'b0;
        tick();
        total_cnt++;
        if (level !== 5'd1)
            $display("FAIL hold_level got %0d exp 1", level);
        else pass_cnt++;
        do_pop(v, d, fe);
        total_cnt++;
        if ({v, d} !== {1'b1, 16'h0077})
            $display("FAIL hold_pop got v=%0b d=%h exp v=1 d=0077", v, d);
        else pass_cnt++;
        rst = 1'b1;
        rx_new_data = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        total_cnt++;
        if (level !== 5'd0 || empty !== 1'b1)
            $display("FAIL high_at_reset got lvl=%0d e=%0b exp lvl=0 e=1", level, empty);
        else pass_cnt++;
        rx_new_data = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        logic v, fe;
        logic [15:0] d;
        for (int i = 0; i < 16; i++) push(16'(i), 1'b0);
        total_cnt++;
        if ({full, overflow, level} !== {1'b1, 1'b0, 5'd16})
            $display("FAIL fill16 got f=%0b o=%0b lvl=%0d exp f=1 o=0 lvl=16", full, overflow, level);
        else pass_cnt++;
        push(16'd16, 1'b0);
        total_cnt++;
        if ({full, overflow, level} !== {1'b1, 1'b1, 5'd16})
            $display("FAIL push17 got f=%0b o=%0b lvl=%0d exp f=1 o=1 lvl=16", full, overflow, level);
        else pass_cnt++;
        rx_data = 16'h0099;
        rx_new_data = 1'b1;
        clear_ovf = 1'b1;
        tick();
        rx_new_data = 1'b0;
        clear_ovf = 1'b0;
        total_cnt++;
        if (overflow !== 1'b1)
            $display("FAIL ovf_set_wins got %0b exp 1", overflow);
        else pass_cnt++;
        tick();
        for (int i = 0; i < 16; i++) begin
            do_pop(v, d, fe);
            total_cnt++;
            if ({v, d} !== {1'b1, 16'(i)})
                $display("FAIL ovf_pop%0d got v=%0b d=%h exp v=1 d=%h", i, v, d, 16'(i));
            else pass_cnt++;
        end
        total_cnt++;
        if ({empty, overflow} !== 2'b11)
            $display("FAIL ovf_drained got e=%0b o=%0b exp e=1 o=1", empty, overflow);
        else pass_cnt++;
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        total_cnt++;
        if (overflow !== 1'b0)
            $display("FAIL clear_ovf got %0b exp 0", overflow);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic v, fe;
        logic [15:0] d;
        logic [15:0] exp_d;
        for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i), 1'b0);
        rx_data = 16'h00AA;
        rx_frame_error = 1'b0;
        rx_new_data = 1'b1;
        rd_en = 1'b1;
        tick();
        rx_new_data = 1'b0;
        rd_en = 1'b0;
        $display("push+pop on full data=00aa -> rd=%h lvl=%0d", rd_data, level);
        total_cnt++;
        if ({rd_valid, rd_data, level, full, overflow} !== {1'b1, 16'h0100, 5'd16, 1'b1, 1'b0})
            $display("FAIL full_push_pop got v=%0b d=%h lvl=%0d f=%0b o=%0b exp v=1 d=0100 lvl=16 f=1 o=0",
                     rd_valid, rd_data, level, full, overflow);
        else pass_cnt++;
        tick();
        for (int i = 1; i <= 16; i++) begin
            exp_d = (i == 16) ? 16'h00AA : 16'h0100 + 16'(i);
            do_pop(v, d, fe);
            total_cnt++;
            if ({v, d} !== {1'b1, exp_d})
                $display("FAIL b2b_pop%0d got v=%0b d=%h exp v=1 d=%h", i, v, d, exp_d);
            else pass_cnt++;
        end
        for (int i = 0; i < 40; i++) begin
            exp_d = 16'h0200 + 16'(i);
            push(exp_d, 1'(i & 1));
            do_pop(v, d, fe);
            total_cnt++;
            if ({v, fe, d} !== {1'b1, 1'(i & 1), exp_d})
                $display("FAIL wrap%0d got v=%0b fe=%0b d=%h exp v=1 fe=%0b d=%h", i, v, fe, d, i & 1, exp_d);
            else pass_cnt++;
        end
    endtask

    task automatic test_ferr_irq();
        logic v, fe;
        logic [15:0] d;
        irq_level = 5'd2;
        push(16'h0055, 1'b1);
        total_cnt++;
        if (irq !== 1'b0)
            $display("FAIL irq_lvl1 got %0b exp 0", irq);
        else pass_cnt++;
        rx_data = 16'h0066;
        rx_frame_error = 1'b0;
        rx_new_data = 1'b1;
        tick();
        rx_new_data = 1'b0;
        total_cnt++;
        if ({level, irq} !== {5'd2, 1'b0})
            $display("FAIL irq_lag got lvl=%0d irq=%0b exp lvl=2 irq=0", level, irq);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (irq !== 1'b1)
            $display("FAIL irq_rise got %0b exp 1", irq);
        else pass_cnt++;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total_cnt++;
        if ({rd_valid, rd_ferr, rd_data, level, irq} !== {1'b1, 1'b1, 16'h0055, 5'd1, 1'b1})
            $display("FAIL ferr1_pop got v=%0b fe=%0b d=%h lvl=%0d irq=%0b exp v=1 fe=1 d=0055 lvl=1 irq=1",
                     rd_valid, rd_ferr, rd_data, level, irq);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (irq !== 1'b0)
            $display("FAIL irq_fall got %0b exp 0", irq);
        else pass_cnt++;
        do_pop(v, d, fe);
        total_cnt++;
        if ({v, fe, d} !== {1'b1, 1'b0, 16'h0066})
            $display("FAIL ferr0_pop got v=%0b fe=%0b d=%h exp v=1 fe=0 d=0066", v, fe, d);
        else pass_cnt++;
        push(16'h0010, 1'b0);
        push(16'h0011, 1'b0);
        total_cnt++;
        if (irq !== 1'b1)
            $display("FAIL irq_again got %0b exp 1", irq);
        else pass_cnt++;
        irq_level = 5'd0;
        tick();
        total_cnt++;
        if (irq !== 1'b0)
            $display("FAIL irq_disable got %0b exp 0", irq);
        else pass_cnt++;
        do_pop(v, d, fe);
        do_pop(v, d, fe);
    endtask

    task automatic test_flush();
        logic v, fe;
        logic [15:0] d;
        for (int i = 0; i < 17; i++) push(16'h0300 + 16'(i), 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total_cnt++;
        if ({level, empty, full, overflow, rd_data} !== {5'd0, 1'b1, 1'b0, 1'b1, 16'h0011})
            $display("FAIL flush_full got lvl=%0d e=%0b f=%0b o=%0b d=%h exp lvl=0 e=1 f=0 o=1 d=0011",
                     level, empty, full, overflow, rd_data);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) push(16'h0400 + 16'(i), 1'b0);
        total_cnt++;
        if (level !== 5'd5)
            $display("FAIL flush_pre_level got %0d exp 5", level);
        else pass_cnt++;
        rx_data = 16'h04FF;
        rx_new_data = 1'b1;
        rd_en = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rd_en = 1'b0;
        rx_new_data = 1'b0;
        $display("flush with push+pop -> lvl=%0d valid=%0b", level, rd_valid);
        total_cnt++;
        if ({level, empty, rd_valid, overflow, rd_data} !== {5'd0, 1'b1, 1'b0, 1'b1, 16'h0011})
            $display("FAIL flush_busy got lvl=%0d e=%0b v=%0b o=%0b d=%h exp lvl=0 e=1 v=0 o=1 d=0011",
                     level, empty, rd_valid, overflow, rd_data);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (level !== 5'd0)
            $display("FAIL flush_no_late_push got %0d exp 0", level);
        else pass_cnt++;
        push(16'h0500, 1'b0);
        do_pop(v, d, fe);
        total_cnt++;
        if ({v, d} !== {1'b1, 16'h0500})
            $display("FAIL flush_reuse got v=%0b d=%h exp v=1 d=0500", v, d);
        else pass_cnt++;
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
    endtask

    task automatic test_rst_mid();
        logic v, fe;
        logic [15:0] d;
        irq_level = 5'd1;
        push(16'h0600, 1'b1);
        for (int i = 1; i < 17; i++) push(16'h0600 + 16'(i), 1'b0);
        do_pop(v, d, fe);
        total_cnt++;
        if ({v, fe, d, overflow, irq} !== {1'b1, 1'b1, 16'h0600, 1'b1, 1'b1})
            $display("FAIL pre_rst got v=%0b fe=%0b d=%h o=%0b irq=%0b exp v=1 fe=1 d=0600 o=1 irq=1",
                     v, fe, d, overflow, irq);
        else pass_cnt++;
        rd_en = 1'b1;
        rst = 1'b1;
        tick();
        rd_en = 1'b0;
        $display("reset mid-stream -> lvl=%0d", level);
        total_cnt++;
        if ({level, empty, full, overflow, irq, rd_valid, rd_ferr, rd_data} !==
            {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000})
            $display("FAIL rst_mid got lvl=%0d e=%0b f=%0b o=%0b i=%0b v=%0b fe=%0b d=%h exp reset values",
                     level, empty, full, overflow, irq, rd_valid, rd_ferr, rd_data);
        else pass_cnt++;
        rst = 1'b0;
        irq_level = 5'd0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_overflow();
        test_back_to_back();
        test_ferr_irq();
        test_flush();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before bench completed");
        $fatal(1);
    end

endmodule
